// File: rtl/layer_seq_ctrl.sv
// layer_seq_ctrl: input pacing and output collection for one fully-connected layer.
// Streams an activation vector into the neurons as a broadcast, waits for every
// neuron result, then re-serialises the results as a valid/ready stream.
// Optional build macro LAYER_ARGMAX_EN adds a class_idx/class_valid argmax result.
`timescale 1ns/1ps

module layer_seq_ctrl #(
  parameter int numInput  = 784,
  parameter int numNeuron = 30,
  parameter int dataWidth = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic signed [dataWidth-1:0]       s_data,
  input  logic                              s_valid,
  output logic                              s_ready,
  output logic signed [dataWidth-1:0]       n_in,
  output logic                              n_in_valid,
  input  logic [numNeuron*dataWidth-1:0]    n_out,
  input  logic [numNeuron-1:0]              n_outvalid,
  output logic signed [dataWidth-1:0]       m_data,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic                              m_last,
  output logic                              busy
`ifdef LAYER_ARGMAX_EN
  ,
  output logic [((numNeuron > 1) ? $clog2(numNeuron) : 1)-1:0] class_idx,
  output logic                              class_valid
`endif
);

  localparam int CW = $clog2(numInput + 1);
  localparam int IW = (numNeuron > 1) ? $clog2(numNeuron) : 1;

  typedef enum logic [1:0] {IDLE, FEED, WAIT, DRAIN} state_t;

  state_t                      state_q, state_d;
  logic [CW-1:0]               in_cnt;
  logic [CW-1:0]               in_cnt_inc;
  logic [IW-1:0]               out_idx;
  logic [IW-1:0]               idx_inc;
  logic [numNeuron-1:0]        done;
  logic [numNeuron-1:0]        done_nxt;
  logic signed [dataWidth-1:0] cap_buf [numNeuron];
  logic                        s_hs;
  logic                        m_hs;

  assign s_hs       = s_valid & s_ready;
  assign m_hs       = m_valid & m_ready;
  assign in_cnt_inc = in_cnt + 1'b1;
  assign idx_inc    = out_idx + 1'b1;
  // Results arriving in the same cycle count toward completion immediately.
  assign done_nxt   = done | ((state_q == WAIT) ? n_outvalid : '0);
  assign busy       = (state_q != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (s_hs) state_d = (numInput == 1) ? WAIT : FEED;
      FEED:  if (s_hs && (in_cnt_inc == CW'(numInput))) state_d = WAIT;
      WAIT:  if (&done_nxt) state_d = DRAIN;
      DRAIN: if (m_hs && m_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Input pacing, broadcast, result capture and output serialisation.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_ready    <= 1'b0;
      n_in       <= '0;
      n_in_valid <= 1'b0;
      in_cnt     <= '0;
      out_idx    <= '0;
      done       <= '0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      for (int i = 0; i < numNeuron; i++) cap_buf[i] <= '0;
    end else begin
      s_ready    <= (state_d == IDLE) || (state_d == FEED);
      n_in_valid <= s_hs;
      if (s_hs) begin
        n_in   <= s_data;
        in_cnt <= (state_q == IDLE) ? CW'(1) : in_cnt_inc;
      end
      if (state_q == WAIT) begin
        for (int i = 0; i < numNeuron; i++)
          if (n_outvalid[i]) cap_buf[i] <= n_out[i*dataWidth +: dataWidth];
        done <= done_nxt;
        if (&done_nxt) begin
          out_idx <= '0;
          m_valid <= 1'b1;
          m_data  <= n_outvalid[0] ? n_out[dataWidth-1:0] : cap_buf[0];
          m_last  <= (numNeuron == 1);
        end
      end
      if ((state_q == DRAIN) && m_hs) begin
        if (m_last) begin
          m_valid <= 1'b0;
          m_last  <= 1'b0;
          done    <= '0;
        end else begin
          out_idx <= idx_inc;
          m_data  <= cap_buf[idx_inc];
          m_last  <= (idx_inc == IW'(numNeuron - 1));
        end
      end
    end
  end

`ifdef LAYER_ARGMAX_EN
  logic signed [dataWidth-1:0] max_val;
  logic [IW-1:0]               max_idx;
  logic                        argmax_take;
  logic [IW-1:0]               argmax_idx;

  // Strict greater-than keeps the lower index on ties.
  assign argmax_take = (out_idx == '0) || (m_data > max_val);
  assign argmax_idx  = argmax_take ? out_idx : max_idx;

  // Running argmax over drained words; result published after the last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_val     <= '0;
      max_idx     <= '0;
      class_idx   <= '0;
      class_valid <= 1'b0;
    end else begin
      class_valid <= 1'b0;
      if ((state_q == DRAIN) && m_hs) begin
        if (argmax_take) begin
          max_val <= m_data;
          max_idx <= out_idx;
        end
        if (m_last) begin
          class_idx   <= argmax_idx;
          class_valid <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Bench for layer_seq_ctrl with numInput=4, numNeuron=3, dataWidth=16.
`timescale 1ns/1ps

module tb_layer_seq_ctrl;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic signed [15:0]  s_data = '0;
  logic                s_valid = 1'b0;
  logic                s_ready;
  logic signed [15:0]  n_in;
  logic                n_in_valid;
  logic [47:0]         n_out = '0;
  logic [2:0]          n_outvalid = '0;
  logic signed [15:0]  m_data;
  logic                m_valid;
  logic                m_ready = 1'b0;
  logic                m_last;
  logic                busy;
`ifdef LAYER_ARGMAX_EN
  logic [1:0]          class_idx;
  logic                class_valid;
`endif

  int total = 0;
  int bad   = 0;

  // Reference state: vector to send, response schedule, expected captured results.
  logic signed [15:0]  vec_w [4];
  logic [2:0]          rsp_mask [8];
  logic signed [15:0]  rsp_val [8][3];
  int                  rsp_n;
  logic signed [15:0]  ref_m [3];
  logic signed [15:0]  last_bcast;

  layer_seq_ctrl #(.numInput(4), .numNeuron(3), .dataWidth(16)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .n_in(n_in), .n_in_valid(n_in_valid),
    .n_out(n_out), .n_outvalid(n_outvalid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy)
`ifdef LAYER_ARGMAX_EN
    , .class_idx(class_idx), .class_valid(class_valid)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (s_ready !== 1'b0)    begin bad++; $display("FAIL rst_s_ready got=%b exp=0", s_ready); end
    total++; if (n_in !== 16'sd0)     begin bad++; $display("FAIL rst_n_in got=%0d exp=0", n_in); end
    total++; if (n_in_valid !== 1'b0) begin bad++; $display("FAIL rst_n_in_valid got=%b exp=0", n_in_valid); end
    total++; if (m_data !== 16'sd0)   begin bad++; $display("FAIL rst_m_data got=%0d exp=0", m_data); end
    total++; if (m_valid !== 1'b0)    begin bad++; $display("FAIL rst_m_valid got=%b exp=0", m_valid); end
    total++; if (m_last !== 1'b0)     begin bad++; $display("FAIL rst_m_last got=%b exp=0", m_last); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
`ifdef LAYER_ARGMAX_EN
    total++; if (class_idx !== 2'd0 || class_valid !== 1'b0)
      begin bad++; $display("FAIL rst_class got=%0d/%b exp=0/0", class_idx, class_valid); end
`endif
    rst = 1'b0;
    last_bcast = '0;
    @(negedge clk);
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL idle_s_ready got=%b exp=1", s_ready); end
  endtask

  // Sends vec_w; a word is broadcast one cycle after it is accepted.
  task automatic send_vector(input int gap_pos, input int gap_len, input bit rnd);
    int sent = 0;
    int cyc = 0;
    int pulses = 0;
    int gap = 0;
    bit prev_hs = 1'b0;
    while (sent < 4 && cyc < 100) begin
      total++; if (n_in_valid !== prev_hs)
        begin bad++; $display("FAIL bcast_valid cyc=%0d got=%b exp=%b", cyc, n_in_valid, prev_hs); end
      total++; if (n_in !== last_bcast)
        begin bad++; $display("FAIL bcast_data cyc=%0d got=%0d exp=%0d", cyc, n_in, last_bcast); end
      total++; if (s_ready !== 1'b1)
        begin bad++; $display("FAIL feed_s_ready cyc=%0d got=%b exp=1", cyc, s_ready); end
      if (n_in_valid === 1'b1) pulses++;
      if (gap > 0) begin s_valid = 1'b0; gap--; end
      else s_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_data = s_valid ? vec_w[sent] : 16'($urandom);
      n_outvalid = 3'($urandom);
      n_out = 48'({$urandom, $urandom});
      prev_hs = s_valid;
      if (s_valid) begin
        last_bcast = vec_w[sent];
        sent++;
        if (sent == gap_pos) gap = gap_len;
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 100) begin total++; bad++; $display("FAIL send_timeout sent=%0d exp=4", sent); end
    s_valid = 1'b0;
    n_outvalid = '0;
    if (n_in_valid === 1'b1) pulses++;
    total++; if (n_in_valid !== 1'b1 || n_in !== last_bcast)
      begin bad++; $display("FAIL bcast_last got=%b/%0d exp=1/%0d", n_in_valid, n_in, last_bcast); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL wait_s_ready got=%b exp=0", s_ready); end
    total++; if (busy !== 1'b1)    begin bad++; $display("FAIL wait_busy got=%b exp=1", busy); end
    total++; if (pulses !== 4)     begin bad++; $display("FAIL bcast_pulses got=%0d exp=4", pulses); end
  endtask

  // Plays rsp_mask/rsp_val against WAIT; output must appear the cycle after completion.
  task automatic respond();
    logic [2:0] done_m = '0;
    for (int k = 0; k < rsp_n; k++) begin
      total++; if (m_valid !== 1'b0)
        begin bad++; $display("FAIL m_valid_early k=%0d got=%b exp=0", k, m_valid); end
      if (k > 0) begin
        total++; if (n_in_valid !== 1'b0)
          begin bad++; $display("FAIL wait_no_bcast k=%0d got=%b exp=0", k, n_in_valid); end
      end
      s_valid = 1'($urandom);
      s_data = 16'($urandom);
      n_outvalid = rsp_mask[k];
      n_out = {rsp_val[k][2], rsp_val[k][1], rsp_val[k][0]};
      for (int i = 0; i < 3; i++) if (rsp_mask[k][i]) ref_m[i] = rsp_val[k][i];
      done_m |= rsp_mask[k];
      @(negedge clk);
    end
    n_outvalid = '0;
    s_valid = 1'b0;
    total++; if (m_valid !== (done_m == 3'b111))
      begin bad++; $display("FAIL m_valid_rise got=%b exp=%b", m_valid, (done_m == 3'b111)); end
  endtask

  // Drains the three results with a leading stall, then optional random backpressure.
  task automatic drain(input int stall, input bit rnd);
    int idx = 0;
    int cyc = 0;
    int best = 0;
    for (int i = 1; i < 3; i++) if (ref_m[i] > ref_m[best]) best = i;
    while (idx < 3 && cyc < 60) begin
      total++; if (m_valid !== 1'b1)
        begin bad++; $display("FAIL drain_valid idx=%0d got=%b exp=1", idx, m_valid); end
      total++; if (m_data !== ref_m[idx])
        begin bad++; $display("FAIL drain_data idx=%0d got=%0d exp=%0d", idx, m_data, ref_m[idx]); end
      total++; if (m_last !== (idx == 2))
        begin bad++; $display("FAIL drain_last idx=%0d got=%b exp=%b", idx, m_last, (idx == 2)); end
      total++; if (s_ready !== 1'b0 || busy !== 1'b1)
        begin bad++; $display("FAIL drain_ctrl got=%b/%b exp=0/1", s_ready, busy); end
      if (stall > 0) begin m_ready = 1'b0; stall--; end
      else m_ready = rnd ? 1'($urandom) : 1'b1;
      n_outvalid = 3'($urandom);
      n_out = 48'({$urandom, $urandom});
      if (m_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 60) begin total++; bad++; $display("FAIL drain_timeout idx=%0d exp=3", idx); end
    m_ready = 1'b0;
    n_outvalid = '0;
    total++; if (m_valid !== 1'b0 || m_last !== 1'b0)
      begin bad++; $display("FAIL post_drain_m got=%b/%b exp=0/0", m_valid, m_last); end
    total++; if (busy !== 1'b0 || s_ready !== 1'b1)
      begin bad++; $display("FAIL post_drain_ctrl busy=%b s_ready=%b exp=0/1", busy, s_ready); end
`ifdef LAYER_ARGMAX_EN
    total++; if (class_valid !== 1'b1 || class_idx !== 2'(best))
      begin bad++; $display("FAIL class_result got=%b/%0d exp=1/%0d", class_valid, class_idx, best); end
    @(negedge clk);
    total++; if (class_valid !== 1'b0 || class_idx !== 2'(best))
      begin bad++; $display("FAIL class_hold got=%b/%0d exp=0/%0d", class_valid, class_idx, best); end
`endif
  endtask

  task automatic set_all_at_once(input logic signed [15:0] a, input logic signed [15:0] b,
                                 input logic signed [15:0] c);
    rsp_n = 1;
    rsp_mask[0] = 3'b111;
    rsp_val[0][0] = a; rsp_val[0][1] = b; rsp_val[0][2] = c;
  endtask

  task automatic test_stream_basic();
    for (int i = 0; i < 4; i++) vec_w[i] = 16'(i + 1);
    send_vector(0, 0, 1'b0);
    set_all_at_once(16'sd5, -16'sd3, 16'sd7);
    respond();
    drain(3, 1'b0);
  endtask

  task automatic test_gap();
    for (int i = 0; i < 4; i++) vec_w[i] = 16'($urandom);
    send_vector(2, 2, 1'b0);
    rsp_n = 3;
    rsp_mask[0] = 3'b001; rsp_mask[1] = 3'b000; rsp_mask[2] = 3'b110;
    for (int k = 0; k < 3; k++) for (int i = 0; i < 3; i++) rsp_val[k][i] = 16'($urandom);
    rsp_val[0][0] = 16'sd9;
    rsp_val[2][1] = 16'sd8;
    rsp_val[2][2] = 16'sd6;
    respond();
    drain(0, 1'b0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) vec_w[i] = 16'($urandom);
    send_vector(0, 0, 1'b1);
    n_outvalid = 3'b001;
    n_out = {16'sd0, 16'sd0, 16'sd9};
    @(negedge clk);
    n_outvalid = '0;
    rst = 1'b1;
    @(negedge clk);
    total++; if (m_valid !== 1'b0 || m_data !== 16'sd0 || m_last !== 1'b0)
      begin bad++; $display("FAIL midrst_m got=%b/%0d/%b exp=0/0/0", m_valid, m_data, m_last); end
    total++; if (n_in !== 16'sd0 || n_in_valid !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL midrst_ctrl n_in=%0d v=%b s_ready=%b busy=%b exp=0", n_in, n_in_valid, s_ready, busy); end
    rst = 1'b0;
    last_bcast = '0;
    @(negedge clk);
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", s_ready); end
    for (int i = 0; i < 4; i++) vec_w[i] = 16'($urandom);
    send_vector(0, 0, 1'b0);
    rsp_n = 2;
    rsp_mask[0] = 3'b110; rsp_mask[1] = 3'b001;
    for (int k = 0; k < 2; k++) for (int i = 0; i < 3; i++) rsp_val[k][i] = 16'($urandom);
    respond();
    drain(0, 1'b0);
  endtask

  task automatic test_random();
    logic [2:0] acc;
    logic [2:0] m;
    for (int it = 0; it < 15; it++) begin
      for (int i = 0; i < 4; i++) vec_w[i] = 16'($urandom);
      send_vector($urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
      acc = '0;
      rsp_n = $urandom_range(1, 6);
      for (int k = 0; k < rsp_n; k++) begin
        m = 3'($urandom);
        if (k == rsp_n - 1) m = ~acc | (m & acc);
        else if ((acc | m) == 3'b111) m = m & acc;
        rsp_mask[k] = m;
        acc |= m;
        for (int i = 0; i < 3; i++) rsp_val[k][i] = 16'($urandom);
      end
      respond();
      drain($urandom_range(0, 2), 1'b1);
    end
  endtask

`ifdef LAYER_ARGMAX_EN
  task automatic test_argmax();
    for (int i = 0; i < 4; i++) vec_w[i] = 16'($urandom);
    send_vector(0, 0, 1'b0);
    set_all_at_once(16'sd5, 16'sd7, 16'sd7);
    respond();
    drain(0, 1'b0);
    for (int i = 0; i < 4; i++) vec_w[i] = 16'($urandom);
    send_vector(0, 0, 1'b0);
    set_all_at_once(-16'sd2, -16'sd9, -16'sd1);
    respond();
    drain(1, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_stream_basic();
    test_gap();
    test_reset_mid();
`ifdef LAYER_ARGMAX_EN
    test_argmax();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/layer_seq_ctrl.md
Name: layer_seq_ctrl

Overview:
Sequencer for one fully-connected layer of neuron instances. It accepts an input activation vector as a valid/ready stream and broadcasts each word to all neurons of the layer. It then waits for every neuron's outvalid, captures the outputs, and re-serialises them as a valid/ready stream for the next layer. The block sits between consecutive layers and owns the layer's input pacing and output collection.

Parameters:
numInput, 784, words per input vector; equals the neurons' numWeight.
numNeuron, 30, neurons in the layer.
dataWidth, 16, activation width, signed two's complement.

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
s_data  input  dataWidth  input activation word
s_valid  input  1  s_data valid
s_ready  output  1  block accepts s_data
n_in  output  dataWidth  broadcast word to all neurons (myinput)
n_in_valid  output  1  broadcast valid (myinputValid)
n_out  input  numNeuron*dataWidth  neuron outputs; neuron i at bits [i*dataWidth +: dataWidth]
n_outvalid  input  numNeuron  per-neuron outvalid
m_data  output  dataWidth  serialised layer output
m_valid  output  1  m_data valid
m_ready  input  1  downstream accepts
m_last  output  1  marks the word from neuron numNeuron-1
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: s_ready=0, n_in=0, n_in_valid=0, m_data=0, m_valid=0, m_last=0, busy=0. State=IDLE; counters, done mask and capture buffer are cleared.
- FSM states: IDLE, FEED, WAIT, DRAIN.
- Handshakes: s handshake = s_valid & s_ready. m handshake = m_valid & m_ready.
- s_ready is registered-state decoded: 1 in IDLE and FEED, 0 in WAIT and DRAIN.
- IDLE:
  - An s handshake counts as word 1 (in_cnt <= 1) and moves to FEED.
  - If numInput==1, the first handshake moves directly to WAIT.
- FEED:
  - Each s handshake increments in_cnt.
  - The handshake that makes in_cnt==numInput moves to WAIT.
  - in_cnt width is $clog2(numInput+1).
- Broadcast latency:
  - A handshake in cycle t gives n_in=s_data and n_in_valid=1 in cycle t+1.
  - n_in_valid=0 in every cycle after a cycle with no handshake. Gaps in s_valid are reproduced as gaps in n_in_valid; the word count is unaffected.
  - n_in holds its last value when n_in_valid=0.
- WAIT:
  - Each cycle, for every i with n_outvalid[i]=1, capture n_out slice i into buf[i] and set done[i].
  - If a bit pulses again, the later value overwrites the earlier one.
  - When done is all ones, including bits set in the current cycle, go to DRAIN next cycle with out_idx=0.
  - n_outvalid is ignored in IDLE, FEED and DRAIN.
- DRAIN:
  - m_valid=1, m_data=buf[out_idx], m_last=(out_idx==numNeuron-1); all three are registered.
  - m_data and m_last stay stable while m_valid=1 and m_ready=0.
  - On an m handshake, out_idx increments and the next word appears the following cycle, giving back-to-back throughput of 1 word/cycle.
  - The handshake with m_last=1 clears m_valid, m_last and done, and returns to IDLE. s_ready=1 the next cycle.
- Reset mid-operation (any state): takes effect on the next edge, with the values listed under Reset values. Partial vectors are discarded.

Optional Feature:
Macro LAYER_ARGMAX_EN.
- With the macro defined:
  - Extra outputs: class_idx, width $clog2(numNeuron), and class_valid, width 1. Both reset to 0.
  - During DRAIN the block tracks the signed maximum of the words handshaked so far. Ties keep the lower index.
  - In the cycle after the m_last handshake: class_idx = index of the maximum, and class_valid pulses high for one cycle.
  - class_idx holds its value until the next result.
- Without the macro: no extra ports and no extra logic.

Test Plan:
1. Params numInput=4, numNeuron=3. Send s_data 1,2,3,4 with s_valid continuously high → n_in_valid high for 4 cycles starting 1 cycle after the first handshake; n_in=1,2,3,4; s_ready=0 the cycle after the 4th handshake.
2. Same params; drop s_valid for 2 cycles after word 2 → n_in_valid shows the same 2-cycle gap; exactly 4 broadcast pulses; state reaches WAIT only after word 4.
3. In WAIT, n_outvalid=3'b111 with outputs 5,-3,7; hold m_ready=0 for 3 cycles, then 1 → m_data stays 5 during the stall; then 5,-3,7 on consecutive handshakes; m_last only on 7; busy=0 the cycle after.
4. n_outvalid bit0 with value 9, then bits 1 and 2 two cycles later with values 8,6 → m_valid rises the cycle after the second pulse; stream is 9,8,6.
5. Assert rst while in WAIT with done=3'b001 → next cycle all outputs 0 and busy=0; a fresh 4-word vector is then processed normally.
6. LAYER_ARGMAX_EN defined; outputs 5,7,7 → class_idx=1 and class_valid high for exactly 1 cycle after the last handshake. With outputs -2,-9,-1 → class_idx=2.
